// File: rtl/layer_sequencer.sv
//------------------------------------------------------------------------------
// layer_sequencer
// Steps one fully-connected layer pass through the address generator and the
// neuron ALU. For each neuron: clear the accumulator, stream the operand reads,
// wait out the ALU pipeline, then strobe the result write.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module layer_sequencer #(
  parameter int N_INPUTS    = 4,
  parameter int N_NEURONS   = 3,
  parameter int ALU_LATENCY = 1,
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  output logic          AG_rst,
  output logic          AG_read,
  output logic          ALU_rst,
  output logic          ALU_forget,
  output logic          out_we,
  output logic [NW-1:0] neuron_idx,
  output logic [IW-1:0] in_idx,
  output logic          busy,
  output logic          done
);

  // Drain counter is wide enough for ALU_LATENCY; kept at 1 bit when latency is 0.
  localparam int DW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  localparam logic [IW-1:0] IN_LAST    = IW'(N_INPUTS - 1);
  localparam logic [NW-1:0] NEUR_LAST  = NW'(N_NEURONS - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((ALU_LATENCY > 0) ? ALU_LATENCY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CLEAR = 3'd2,
    S_ACCUM = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   drain_cnt;
  logic            read_en;
  logic            last_read;

  // An operand is consumed on every non-stalled ACCUM cycle.
  assign read_en   = (state == S_ACCUM) && !stall;
  assign last_read = read_en && (in_idx == IN_LAST);

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every other transition outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_ACCUM;
      S_ACCUM: if (last_read) state_nxt = (ALU_LATENCY == 0) ? S_WRITE : S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (neuron_idx == NEUR_LAST) ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end
  end

  // Operand, neuron and drain counters; all clear in IDLE and on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_idx     <= '0;
      neuron_idx <= '0;
      drain_cnt  <= '0;
    end else if (abort || (state == S_IDLE)) begin
      in_idx     <= '0;
      neuron_idx <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_CLEAR: in_idx <= '0;
        S_ACCUM: begin
          if (last_read) begin
            in_idx    <= '0;
            drain_cnt <= DRAIN_LOAD;
          end else if (read_en) begin
            in_idx <= in_idx + 1'b1;
          end
        end
        S_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        S_WRITE: if (neuron_idx != NEUR_LAST) neuron_idx <= neuron_idx + 1'b1;
        S_DONE:  neuron_idx <= '0;
        default: ;
      endcase
    end
  end

  // Output decode from state. Besides the stall gating of AG_read, abort masks
  // the write strobe and done in the cycle it cancels the pass, so an aborted
  // WRITE or DONE cycle never commits anything.
  always_comb begin
    AG_rst     = 1'b0;
    AG_read    = 1'b0;
    ALU_rst    = 1'b0;
    ALU_forget = 1'b0;
    out_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        AG_rst  = 1'b1;
        ALU_rst = 1'b1;
        busy    = 1'b0;
      end
      S_INIT:  AG_rst     = 1'b1;
      S_CLEAR: ALU_forget = 1'b1;
      S_ACCUM: AG_read    = read_en;
      S_WRITE: out_we     = !abort;
      S_DONE:  done       = !abort;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
//------------------------------------------------------------------------------
// tb_layer_sequencer
// Self-checking bench: default-parameter instance with a write-strobe
// scoreboard, plus a minimal (1 input, 1 neuron, zero latency) instance.
//------------------------------------------------------------------------------
`default_nettype none

module tb_layer_sequencer;

  logic clk;
  logic reset;
  logic start, stall, abort;
  logic AG_rst, AG_read, ALU_rst, ALU_forget, out_we, busy, done;
  logic [1:0] neuron_idx;
  logic [1:0] in_idx;

  logic s_start, s_stall, s_abort;
  logic s_AG_rst, s_AG_read, s_ALU_rst, s_ALU_forget, s_out_we, s_busy, s_done;
  logic [0:0] s_neuron_idx;
  logic [0:0] s_in_idx;

  int checks = 0;
  int errors = 0;
  int sb_q[$];
  int mon_exp;

  layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .abort(abort),
    .AG_rst(AG_rst), .AG_read(AG_read), .ALU_rst(ALU_rst), .ALU_forget(ALU_forget),
    .out_we(out_we), .neuron_idx(neuron_idx), .in_idx(in_idx), .busy(busy), .done(done)
  );

  layer_sequencer #(.N_INPUTS(1), .N_NEURONS(1), .ALU_LATENCY(0)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .stall(s_stall), .abort(s_abort),
    .AG_rst(s_AG_rst), .AG_read(s_AG_read), .ALU_rst(s_ALU_rst), .ALU_forget(s_ALU_forget),
    .out_we(s_out_we), .neuron_idx(s_neuron_idx), .in_idx(s_in_idx), .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the next expected neuron index.
  always @(negedge clk) begin
    if (reset && out_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_we: got out_we with neuron_idx=%0d, required none", neuron_idx);
      end else begin
        mon_exp = sb_q.pop_front();
        if (neuron_idx !== 2'(mon_exp)) begin
          errors++;
          $display("FAIL sb_neuron_idx: got %0d, required %0d", neuron_idx, mon_exp);
        end
      end
    end
  end

  // Stimulus/measurement only: pulse start, optionally stall, count events.
  task automatic run_pass(input int stall_from, input int stall_n,
                          output int len, output int reads, output int forgets,
                          output int wes, output int agrst_bad, output int frozen_bad);
    logic [1:0] prev_idx;
    bit prev_stall;
    len = 0; reads = 0; forgets = 0; wes = 0; agrst_bad = 0; frozen_bad = 0;
    prev_idx = '0; prev_stall = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      stall = (cyc >= stall_from) && (cyc < stall_from + stall_n);
      @(negedge clk);
      if (AG_read) reads++;
      if (ALU_forget) forgets++;
      if (out_we) wes++;
      if (AG_rst && cyc != 1) agrst_bad++;
      if (prev_stall && in_idx !== prev_idx) frozen_bad++;
      prev_stall = stall;
      prev_idx = in_idx;
      if (done) begin
        len = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({AG_rst, ALU_rst, AG_read, ALU_forget, out_we, busy, done} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 1100000",
               {AG_rst, ALU_rst, AG_read, ALU_forget, out_we, busy, done});
    end
    checks++;
    if ({neuron_idx, in_idx} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_counters: got %b, required 0000", {neuron_idx, in_idx});
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b s_busy=%b, required 0 0", busy, s_busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int len, reads, forgets, wes, agb, frz;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    run_pass(0, 0, len, reads, forgets, wes, agb, frz);
    checks++;
    if (len != 23) begin errors++; $display("FAIL basic_len: got %0d, required 23", len); end
    checks++;
    if (reads != 12) begin errors++; $display("FAIL basic_reads: got %0d, required 12", reads); end
    checks++;
    if (forgets != 3) begin errors++; $display("FAIL basic_forgets: got %0d, required 3", forgets); end
    checks++;
    if (wes != 3) begin errors++; $display("FAIL basic_we: got %0d, required 3", wes); end
    checks++;
    if (agb != 0) begin errors++; $display("FAIL basic_ag_rst: got %0d busy cycles beyond INIT, required 0", agb); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL basic_sb_left: got %0d pending, required 0", sb_q.size()); end
    checks++;
    if ({busy, AG_rst, ALU_rst} !== 3'b011) begin
      errors++;
      $display("FAIL basic_idle_after: got %b, required 011", {busy, AG_rst, ALU_rst});
    end
  endtask

  task automatic test_stall();
    int len, reads, forgets, wes, agb, frz;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    run_pass(11, 3, len, reads, forgets, wes, agb, frz);
    checks++;
    if (len != 26) begin errors++; $display("FAIL stall_len: got %0d, required 26", len); end
    checks++;
    if (reads != 12) begin errors++; $display("FAIL stall_reads: got %0d, required 12", reads); end
    checks++;
    if (frz != 0) begin errors++; $display("FAIL stall_in_idx_frozen: got %0d changes, required 0", frz); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL stall_sb_left: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    int done1, done2;
    logic b24, b25;
    done1 = 0; done2 = 0; b24 = 1'bx; b25 = 1'bx;
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      start = (cyc <= 25) || (cyc == 30);
      @(negedge clk);
      if (cyc == 24) b24 = busy;
      if (cyc == 25) b25 = busy;
      if (done && done1 == 0) done1 = cyc;
      else if (done && done2 == 0) done2 = cyc;
      if (done2 != 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done1 != 23) begin errors++; $display("FAIL b2b_first_done: got %0d, required 23", done1); end
    checks++;
    if ({b24, b25} !== 2'b01) begin errors++; $display("FAIL b2b_gap: got busy %b%b, required 01", b24, b25); end
    checks++;
    if (done2 != 47) begin errors++; $display("FAIL b2b_second_done: got %0d, required 47", done2); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got busy=%b, required 0", busy); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_sb_left: got %0d pending, required 0", sb_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int late_done;
    late_done = 0;
    sb_q.push_back(0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (neuron_idx !== 2'd1) begin errors++; $display("FAIL abort_at_neuron1: got %0d, required 1", neuron_idx); end
    checks++;
    if ({out_we, done} !== 2'b00) begin errors++; $display("FAIL abort_no_we: got we/done %b, required 00", {out_we, done}); end
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, AG_rst, ALU_rst} !== 3'b011) begin
      errors++;
      $display("FAIL abort_idle: got busy/AG_rst/ALU_rst %b, required 011", {busy, AG_rst, ALU_rst});
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles, required 0", late_done); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL abort_sb_left: got %0d pending, required 0", sb_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int len, reads, forgets, wes, agb, frz;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({AG_read, in_idx} !== 3'b101) begin
      errors++;
      $display("FAIL areset_pre_accum: got AG_read/in_idx %b, required 101", {AG_read, in_idx});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({AG_rst, ALU_rst, AG_read, ALU_forget, out_we, busy, done, neuron_idx, in_idx} !== 11'b11000000000) begin
      errors++;
      $display("FAIL areset_immediate: got %b, required 11000000000",
               {AG_rst, ALU_rst, AG_read, ALU_forget, out_we, busy, done, neuron_idx, in_idx});
    end
    @(posedge clk); #1 reset = 1'b1;
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    run_pass(0, 0, len, reads, forgets, wes, agb, frz);
    checks++;
    if (len != 23) begin errors++; $display("FAIL areset_pass_len: got %0d, required 23", len); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL areset_sb_left: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_small();
    int c_forget, c_read, c_we, c_done, n_read;
    logic we_idx;
    c_forget = 0; c_read = 0; c_we = 0; c_done = 0; n_read = 0; we_idx = 1'bx;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (s_ALU_forget && c_forget == 0) c_forget = cyc;
      if (s_AG_read) begin n_read++; if (c_read == 0) c_read = cyc; end
      if (s_out_we && c_we == 0) begin c_we = cyc; we_idx = s_neuron_idx[0]; end
      if (s_done) begin c_done = cyc; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (c_done != 5) begin errors++; $display("FAIL small_len: got %0d, required 5", c_done); end
    checks++;
    if (c_forget != 2 || c_read != 3) begin
      errors++;
      $display("FAIL small_forget_read: got forget@%0d read@%0d, required 2 3", c_forget, c_read);
    end
    checks++;
    if (c_we != 4 || we_idx !== 1'b0) begin
      errors++;
      $display("FAIL small_we: got we@%0d idx=%b, required 4 0", c_we, we_idx);
    end
    checks++;
    if (n_read != 1) begin errors++; $display("FAIL small_reads: got %0d, required 1", n_read); end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_stall = 1'b0; s_abort = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
